wash_runner: RTL and testbench
==============================

WASH_RUNNER -- requirements
Module: wash_runner

Interface
REQ-001 Parameter TG_WAS, 4, wash time units per water unit.
REQ-002 Parameter TG_RIN, 3, rinse time units per water unit.
REQ-003 Parameter TG_DRY, 5, dry time units per water unit.
REQ-004 Parameter BUZZ_T, 3, buzzer duration in ticks after completion.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 tr_run  input  1  one-cycle start/pause/resume pulse.
REQ-008 clr  input  1  one-cycle abort pulse.
REQ-009 tick  input  1  one-cycle time-unit strobe.
REQ-010 mode  input  3  phase select from settings stage: bit0 wash, bit1 rinse, bit2 dry.
REQ-011 u_wat  input  6  water level from settings stage, legal range 2..5.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 paused  output  1  high only in PAUSE.
REQ-014 ld_drw  output  3  phase lamp mask.
REQ-015 rem_tot  output  6  remaining time units, whole program.
REQ-016 rem_cur  output  6  remaining time units, current phase.
REQ-017 finished  output  1  one-cycle pulse on program completion.
REQ-018 buzz  output  1  high during DONE.
REQ-019 set_clr  output  1  one-cycle pulse on DONE->IDLE, drives the settings-stage clr.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN, PAUSE and DONE.
REQ-021 The phase order SHALL be wash, rinse, dry, skipping phases whose mode bit is 0.
REQ-022 Phase duration SHALL be u_wat*TG_x, computed at 6-bit width; the parameter defaults keep the maximum at 60, so overflow does not occur.
REQ-023 IDLE outputs: ld_drw = live mode; rem_tot = live sum of the selected durations; rem_cur = live duration of the first selected phase; mode=000 gives 0/0.
REQ-024 IDLE with tr_run and mode!=000: the block SHALL latch mode and u_wat into shadow registers, load rem_tot and rem_cur, and enter RUN on the next edge.
REQ-025 IDLE with tr_run and mode=000: the pulse SHALL be ignored and the block stays in IDLE.
REQ-026 RUN/PAUSE/DONE SHALL use only the shadow copies; changes on mode and u_wat SHALL have no effect.
REQ-027 In RUN, ld_drw SHALL be the shadow mask with already-completed phases cleared.
REQ-028 RUN tick, rem_cur>1: rem_cur and rem_tot SHALL each decrement by 1.
REQ-029 RUN tick, rem_cur==1, a later phase is selected: rem_tot decrements, that phase's bit clears in ld_drw, and rem_cur loads the next phase's duration in the same cycle.
REQ-030 RUN tick, rem_cur==1, no later phase: the block SHALL enter DONE with rem_tot=rem_cur=0, ld_drw=000, and pulse finished for one cycle.
REQ-031 RUN with tr_run: the block SHALL enter PAUSE.
REQ-032 PAUSE: ticks SHALL be ignored and counters held; tr_run SHALL return the block to RUN.
REQ-033 Same-cycle tr_run and tick in RUN: pause wins and the tick is discarded, no decrement.
REQ-034 Same-cycle tr_run and tick in PAUSE: resume only; the tick is discarded.
REQ-035 DONE: buzz SHALL be high; the block SHALL count BUZZ_T ticks, then go to IDLE and pulse set_clr for one cycle.
REQ-036 DONE: tr_run SHALL end the buzzer early with the same IDLE transition and set_clr pulse.
REQ-037 clr in any state SHALL force IDLE on the next edge with no finished or set_clr pulse.
REQ-038 Priority SHALL be rst > clr > tr_run > tick.

Reset
REQ-039 rst SHALL force IDLE, clear the shadow registers and buzzer counter, and hold busy=paused=finished=buzz=set_clr=0; ld_drw, rem_tot and rem_cur then follow the live inputs per REQ-023.
REQ-040 rst mid-run SHALL abandon the program with no finished pulse.

Verification
REQ-041 mode=111, u_wat=3, tr_run -> rem_tot=36, rem_cur=12; after 12 ticks ld_drw=110, rem_cur=9, rem_tot=24; after 36 ticks finished pulses once, buzz for 3 ticks, then set_clr pulses and IDLE.
REQ-042 mode=010, u_wat=2, run -> rem_tot=6, ld_drw=010; 6 ticks -> DONE; changing u_wat to 5 mid-run has no effect.
REQ-043 mode=111, u_wat=5, run, 10 ticks, then tr_run -> PAUSE; 7 ticks leave rem_tot=50; tr_run, then 50 ticks -> DONE.
REQ-044 In RUN, tr_run and tick in the same cycle -> PAUSE with counters unchanged; clr during RUN -> IDLE next cycle, no finished pulse.
REQ-045 rst asserted mid-run -> IDLE, busy=0, no finished or set_clr; a later tr_run with mode=000 -> stays IDLE.

Source files
------------

// File: rtl/wash_runner.sv
// wash_runner: wash/rinse/dry program sequencer with pause, abort and buzzer.
// Settings (mode, u_wat) are shadowed on start; the running program never
// looks at the live inputs again until it returns to IDLE.
module wash_runner #(
    parameter int unsigned TG_WAS = 4,
    parameter int unsigned TG_RIN = 3,
    parameter int unsigned TG_DRY = 5,
    parameter int unsigned BUZZ_T = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tr_run,
    input  logic       clr,
    input  logic       tick,
    input  logic [2:0] mode,
    input  logic [5:0] u_wat,
    output logic       busy,
    output logic       paused,
    output logic [2:0] ld_drw,
    output logic [5:0] rem_tot,
    output logic [5:0] rem_cur,
    output logic       finished,
    output logic       buzz,
    output logic       set_clr
);

    localparam int unsigned BW = (BUZZ_T > 1) ? $clog2(BUZZ_T) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state, state_nxt;
    logic [5:0]    sh_wat, wat_nxt;
    logic [2:0]    sh_mask, mask_nxt;     // phases still to run, current one included
    logic [5:0]    tot_q, tot_nxt;
    logic [5:0]    cur_q, cur_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic          fin_q, fin_nxt;
    logic          sclr_q, sclr_nxt;
    logic [2:0]    rest;

    function automatic logic [5:0] dur(input logic [5:0] w, input int unsigned tg);
        return 6'(w * 6'(tg));
    endfunction

    function automatic logic [5:0] first_dur(input logic [2:0] m, input logic [5:0] w);
        logic [5:0] d;
        d = '0;
        if (m[0])      d = dur(w, TG_WAS);
        else if (m[1]) d = dur(w, TG_RIN);
        else if (m[2]) d = dur(w, TG_DRY);
        return d;
    endfunction

    function automatic logic [5:0] sum_dur(input logic [2:0] m, input logic [5:0] w);
        logic [5:0] s;
        s = '0;
        if (m[0]) s = s + dur(w, TG_WAS);
        if (m[1]) s = s + dur(w, TG_RIN);
        if (m[2]) s = s + dur(w, TG_DRY);
        return s;
    endfunction

    // State and datapath registers; pulses are registered so they last one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sh_wat  <= '0;
            sh_mask <= '0;
            tot_q   <= '0;
            cur_q   <= '0;
            bcnt    <= '0;
            fin_q   <= 1'b0;
            sclr_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            sh_wat  <= wat_nxt;
            sh_mask <= mask_nxt;
            tot_q   <= tot_nxt;
            cur_q   <= cur_nxt;
            bcnt    <= bcnt_nxt;
            fin_q   <= fin_nxt;
            sclr_q  <= sclr_nxt;
        end
    end

    // Next-state logic (clr > tr_run > tick) and output decode.
    always_comb begin
        state_nxt = state;
        wat_nxt   = sh_wat;
        mask_nxt  = sh_mask;
        tot_nxt   = tot_q;
        cur_nxt   = cur_q;
        bcnt_nxt  = bcnt;
        fin_nxt   = 1'b0;
        sclr_nxt  = 1'b0;
        // clearing the lowest set bit retires the phase that just ended
        rest      = sh_mask & (sh_mask - 3'd1);

        if (clr) begin
            state_nxt = IDLE;
            bcnt_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tr_run && mode != 3'b000) begin
                        wat_nxt   = u_wat;
                        mask_nxt  = mode;
                        tot_nxt   = sum_dur(mode, u_wat);
                        cur_nxt   = first_dur(mode, u_wat);
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (tr_run) begin
                        state_nxt = PAUSE;
                    end else if (tick) begin
                        tot_nxt = tot_q - 6'd1;
                        if (cur_q > 6'd1) begin
                            cur_nxt = cur_q - 6'd1;
                        end else if (rest != 3'b000) begin
                            mask_nxt = rest;
                            cur_nxt  = first_dur(rest, sh_wat);
                        end else begin
                            mask_nxt  = '0;
                            tot_nxt   = '0;
                            cur_nxt   = '0;
                            bcnt_nxt  = '0;
                            fin_nxt   = 1'b1;
                            state_nxt = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (tr_run) state_nxt = RUN;
                end
                DONE: begin
                    if (tr_run || (tick && bcnt == BW'(BUZZ_T - 1))) begin
                        sclr_nxt  = 1'b1;
                        bcnt_nxt  = '0;
                        state_nxt = IDLE;
                    end else if (tick) begin
                        bcnt_nxt = bcnt + BW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        busy     = (state != IDLE);
        paused   = (state == PAUSE);
        buzz     = (state == DONE);
        finished = fin_q;
        set_clr  = sclr_q;
        if (state == IDLE) begin
            ld_drw  = mode;
            rem_tot = sum_dur(mode, u_wat);
            rem_cur = first_dur(mode, u_wat);
        end else begin
            ld_drw  = sh_mask;
            rem_tot = tot_q;
            rem_cur = cur_q;
        end
    end

endmodule

// File: tb/tb_wash_runner.sv
// Self-checking bench for wash_runner: directed scenarios plus randomized
// traffic compared each cycle against an elapsed-time reference model.
module tb_wash_runner;

    localparam int unsigned TG_WAS = 4;
    localparam int unsigned TG_RIN = 3;
    localparam int unsigned TG_DRY = 5;
    localparam int unsigned BUZZ_T = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tr_run = 1'b0;
    logic       clr = 1'b0;
    logic       tick = 1'b0;
    logic [2:0] mode = 3'b000;
    logic [5:0] u_wat = 6'd2;
    logic       busy, paused, finished, buzz, set_clr;
    logic [2:0] ld_drw;
    logic [5:0] rem_tot, rem_cur;

    int errors = 0;
    int checks = 0;

    wash_runner #(.TG_WAS(TG_WAS), .TG_RIN(TG_RIN), .TG_DRY(TG_DRY), .BUZZ_T(BUZZ_T)) dut (
        .clk(clk), .rst(rst), .tr_run(tr_run), .clr(clr), .tick(tick),
        .mode(mode), .u_wat(u_wat), .busy(busy), .paused(paused),
        .ld_drw(ld_drw), .rem_tot(rem_tot), .rem_cur(rem_cur),
        .finished(finished), .buzz(buzz), .set_clr(set_clr)
    );

    always #5 clk = ~clk;

    // Reference model: program progress is "ticks elapsed since start".
    typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mst_t;
    mst_t       m_st = M_IDLE;
    logic [2:0] m_mode = '0;
    int         m_wat = 0;
    int         m_el = 0;
    int         m_buzz = 0;
    logic       m_fin = 1'b0;
    logic       m_sclr = 1'b0;

    function automatic int prog_total(input logic [2:0] m, input int w);
        int t;
        t = 0;
        if (m[0]) t += w * TG_WAS;
        if (m[1]) t += w * TG_RIN;
        if (m[2]) t += w * TG_DRY;
        return t;
    endfunction

    function automatic logic [19:0] exp_vec();
        logic [2:0] m, ld;
        int w, el, cum, cur, tot, i;
        int d[3];
        bit found;
        if (m_st == M_IDLE) begin m = mode; w = int'(u_wat); el = 0; end
        else begin m = m_mode; w = m_wat; el = m_el; end
        d[0] = m[0] ? w * TG_WAS : 0;
        d[1] = m[1] ? w * TG_RIN : 0;
        d[2] = m[2] ? w * TG_DRY : 0;
        tot = d[0] + d[1] + d[2] - el;
        cum = 0; cur = 0; ld = '0; found = 0;
        for (i = 0; i < 3; i++) begin
            if (!found && el < cum + d[i]) begin
                found = 1;
                cur = cum + d[i] - el;
                ld = m & ~3'((1 << i) - 1);
            end
            cum += d[i];
        end
        return {m_st != M_IDLE, m_st == M_HOLD, ld, 6'(tot), 6'(cur), m_fin, m_st == M_DONE, m_sclr};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {busy, paused, ld_drw, rem_tot, rem_cur, finished, buzz, set_clr};
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle 1 time unit.
    task automatic step(input logic r, input logic c, input logic t, input logic k);
        @(negedge clk);
        rst = r; clr = c; tr_run = t; tick = k;
        @(posedge clk);
        m_fin = 1'b0;
        m_sclr = 1'b0;
        if (r) begin
            m_st = M_IDLE; m_mode = '0; m_wat = 0; m_el = 0; m_buzz = 0;
        end else if (c) begin
            m_st = M_IDLE;
        end else begin
            case (m_st)
                M_IDLE: if (t && mode != 3'b000) begin
                    m_mode = mode; m_wat = int'(u_wat); m_el = 0; m_st = M_RUN;
                end
                M_RUN: if (t) m_st = M_HOLD;
                    else if (k) begin
                        m_el++;
                        if (m_el == prog_total(m_mode, m_wat)) begin
                            m_st = M_DONE; m_fin = 1'b1; m_buzz = 0;
                        end
                    end
                M_HOLD: if (t) m_st = M_RUN;
                M_DONE: if (t) begin m_st = M_IDLE; m_sclr = 1'b1; end
                    else if (k) begin
                        m_buzz++;
                        if (m_buzz == BUZZ_T) begin m_st = M_IDLE; m_sclr = 1'b1; end
                    end
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_vec: got %h expected %h", dut_vec(), exp_vec());
        end
        checks++;
        if ({busy, paused, finished, buzz, set_clr} !== 5'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, paused, finished, buzz, set_clr});
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_full_program();
        int fins;
        mode = 3'b111; u_wat = 6'd3;
        step(0, 0, 1, 0);
        checks++;
        if ({rem_tot, rem_cur} !== {6'd36, 6'd12}) begin
            errors++; $display("FAIL start_load: got tot=%0d cur=%0d expected tot=36 cur=12", rem_tot, rem_cur);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL wash_vec: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({ld_drw, rem_cur, rem_tot} !== {3'b110, 6'd9, 6'd24}) begin
            errors++; $display("FAIL phase_change: got ld=%b cur=%0d tot=%0d expected ld=110 cur=9 tot=24", ld_drw, rem_cur, rem_tot);
        end
        fins = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 0, 1);
            fins += int'(finished);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL rest_vec: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        step(0, 0, 0, 0);
        fins += int'(finished);
        checks++;
        if (fins != 1 || buzz !== 1'b1) begin
            errors++; $display("FAIL finish_pulse: got pulses=%0d buzz=%b expected pulses=1 buzz=1", fins, buzz);
        end
        for (int i = 0; i < BUZZ_T; i++) begin
            step(0, 0, 0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL buzz_vec: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({set_clr, busy} !== 2'b10) begin
            errors++; $display("FAIL buzz_end: got set_clr=%b busy=%b expected 1 0", set_clr, busy);
        end
        step(0, 0, 0, 0);
        checks++;
        if (set_clr !== 1'b0) begin
            errors++; $display("FAIL set_clr_len: got %b expected 0", set_clr);
        end
    endtask

    task automatic test_shadow_rinse();
        mode = 3'b010; u_wat = 6'd2;
        step(0, 0, 1, 0);
        checks++;
        if ({rem_tot, ld_drw} !== {6'd6, 3'b010}) begin
            errors++; $display("FAIL rinse_load: got tot=%0d ld=%b expected 6 010", rem_tot, ld_drw);
        end
        for (int i = 0; i < 6; i++) begin
            if (i == 3) u_wat = 6'd5;
            step(0, 0, 0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL rinse_vec: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({buzz, finished} !== 2'b11) begin
            errors++; $display("FAIL rinse_done: got buzz=%b fin=%b expected 1 1", buzz, finished);
        end
        step(0, 0, 1, 0);
        checks++;
        if ({set_clr, busy} !== 2'b10) begin
            errors++; $display("FAIL early_stop: got set_clr=%b busy=%b expected 1 0", set_clr, busy);
        end
    endtask

    task automatic test_pause();
        int fins;
        mode = 3'b111; u_wat = 6'd5;
        step(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        checks++;
        if (paused !== 1'b1) begin
            errors++; $display("FAIL pause_enter: got paused=%b expected 1", paused);
        end
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
        checks++;
        if (rem_tot !== 6'd50) begin
            errors++; $display("FAIL pause_hold: got tot=%0d expected 50", rem_tot);
        end
        step(0, 0, 1, 0);
        fins = 0;
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 0, 1);
            fins += int'(finished);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL resume_vec: got %h expected %h", dut_vec(), exp_vec());
            end
        end
        checks++;
        if (fins != 1 || buzz !== 1'b1) begin
            errors++; $display("FAIL resume_done: got pulses=%0d buzz=%b expected 1 1", fins, buzz);
        end
        step(0, 1, 0, 0);
    endtask

    task automatic test_collisions();
        mode = 3'b111; u_wat = 6'd4;
        step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        checks++;
        if ({paused, rem_tot, rem_cur} !== {1'b1, 6'd43, 6'd11}) begin
            errors++; $display("FAIL pause_wins: got p=%b tot=%0d cur=%0d expected 1 43 11", paused, rem_tot, rem_cur);
        end
        step(0, 0, 1, 1);
        checks++;
        if ({busy, paused, rem_tot} !== {1'b1, 1'b0, 6'd43}) begin
            errors++; $display("FAIL resume_only: got b=%b p=%b tot=%0d expected 1 0 43", busy, paused, rem_tot);
        end
        step(0, 1, 1, 1);
        checks++;
        if ({busy, finished, set_clr} !== 3'b000) begin
            errors++; $display("FAIL clr_abort: got %b expected 000", {busy, finished, set_clr});
        end
    endtask

    task automatic test_reset_midrun();
        mode = 3'b101; u_wat = 6'd2;
        step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        checks++;
        if ({busy, finished, set_clr} !== 3'b000) begin
            errors++; $display("FAIL rst_midrun: got %b expected 000", {busy, finished, set_clr});
        end
        mode = 3'b000;
        step(0, 0, 1, 0);
        checks++;
        if ({busy, ld_drw, rem_tot, rem_cur} !== 16'h0) begin
            errors++; $display("FAIL empty_start: got %h expected 0000", {busy, ld_drw, rem_tot, rem_cur});
        end
    endtask

    task automatic test_random();
        logic r, c, t, k;
        for (int it = 0; it < 12; it++) begin
            mode = 3'($urandom_range(1, 7));
            u_wat = 6'($urandom_range(2, 5));
            step(0, 0, 1, 0);
            for (int n = 0; n < 180; n++) begin
                r = ($urandom_range(0, 299) == 0);
                c = ($urandom_range(0, 149) == 0);
                t = ($urandom_range(0, 14) == 0);
                k = ($urandom_range(0, 1) == 0);
                if ($urandom_range(0, 29) == 0) begin
                    mode = 3'($urandom_range(0, 7));
                    u_wat = 6'($urandom_range(2, 5));
                end
                step(r, c, t, k);
                checks++;
                if (dut_vec() !== exp_vec()) begin
                    errors++; $display("FAIL random_vec: got %h expected %h", dut_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_program();
        test_shadow_rinse();
        test_pause();
        test_collisions();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
